// File: rtl/twiddle_seq_rom.sv
// Twiddle-factor source for a radix-2 DIT FFT. It streams the W_N^k sequence for one stage
// over valid/ready. The N/2-entry table is computed at elaboration unless ROM_IMG is supplied.
module twiddle_seq_rom #(
    parameter int LOG2N = 4,
    parameter int TW_W  = 28,
    parameter int SW    = $clog2(LOG2N + 1),
    parameter bit USE_IMG = 1'b0,
    parameter logic [(1 << (LOG2N - 1)) * TW_W - 1:0] ROM_IMG = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SW-1:0]      stage_sel,
    input  logic               conj,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               tw_valid,
    input  logic               tw_ready,
    output logic [TW_W-1:0]    tw_data,
    output logic [LOG2N-2:0]   tw_idx,
    output logic               tw_last
);
    // state | meaning
    // IDLE  | waiting for start; rejects illegal stages with err
    // RUN   | streaming butterflies j = 0..N/2-1 of the latched stage

    localparam int HALF     = 1 << (LOG2N - 1);
    localparam int IW       = LOG2N - 1;
    localparam int CW       = TW_W / 2;
    localparam int FRAC     = CW - 2;
    localparam int ROM_BITS = HALF * TW_W;
    localparam real PI      = 3.14159265358979323846;

    localparam logic [IW:0]   J_END    = (IW + 1)'(HALF);
    localparam logic [IW:0]   J_LAST   = (IW + 1)'(HALF - 1);
    localparam logic [SW-1:0] STAGE_MAX = SW'(LOG2N);
    localparam logic [CW-1:0] IM_NEG  = {1'b1, {(CW - 1){1'b0}}};
    localparam logic [CW-1:0] IM_POS  = {1'b0, {(CW - 1){1'b1}}};

    function automatic int round_near(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(0.5 - x);
    endfunction

    function automatic logic [ROM_BITS-1:0] build_rom();
        logic [ROM_BITS-1:0] img;
        logic [CW-1:0]       re_b, im_b;
        real                 ang, scale;
        int                  re_i, im_i;
        img   = '0;
        scale = real'(1 << FRAC);
        for (int k = 0; k < HALF; k++) begin
            ang  = 2.0 * PI * real'(k) / real'(2 * HALF);
            re_i = round_near(scale * $cos(ang));
            im_i = round_near(-scale * $sin(ang));
            re_b = re_i[CW-1:0];
            im_b = im_i[CW-1:0];
            img[k*TW_W +: TW_W] = {re_b, im_b};
        end
        return img;
    endfunction

    localparam logic [ROM_BITS-1:0] ROM = USE_IMG ? ROM_IMG : build_rom();

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    logic [IW:0]     j;
    logic [IW-1:0]   k_mask;
    logic [SW-1:0]   k_shift;
    logic            conj_q;

    logic            stage_ok;
    logic [IW-1:0]   mask_new;
    logic [SW-1:0]   shift_new;
    logic [IW-1:0]   k;
    logic [TW_W-1:0] rom_word;
    logic [CW-1:0]   im_raw, im_conj;
    logic [TW_W-1:0] out_word;

    assign stage_ok  = (stage_sel != '0) && (stage_sel <= STAGE_MAX);
    // a shift of IW clears every bit, so the last stage gets the full mask
    assign mask_new  = ~({IW{1'b1}} << (stage_sel - SW'(1)));
    assign shift_new = STAGE_MAX - stage_sel;

    always_comb begin
        k        = (j[IW-1:0] & k_mask) << k_shift;
        rom_word = ROM[int'(k)*TW_W +: TW_W];
        im_raw   = rom_word[CW-1:0];
        im_conj  = (im_raw == IM_NEG) ? IM_POS : -im_raw;
        out_word = conj_q ? {rom_word[TW_W-1:CW], im_conj} : rom_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            tw_valid <= 1'b0;
            tw_last  <= 1'b0;
            tw_data  <= '0;
            tw_idx   <= '0;
            j        <= '0;
            k_mask   <= '0;
            k_shift  <= '0;
            conj_q   <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (stage_ok) begin
                            state   <= RUN;
                            busy    <= 1'b1;
                            j       <= '0;
                            k_mask  <= mask_new;
                            k_shift <= shift_new;
                            conj_q  <= conj;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!tw_valid || tw_ready) begin
                        if (j != J_END) begin
                            tw_valid <= 1'b1;
                            tw_data  <= out_word;
                            tw_idx   <= k;
                            tw_last  <= (j == J_LAST);
                            j        <= j + 1'b1;
                        end else begin
                            // j exhausted, so this is the handshake of the last beat
                            tw_valid <= 1'b0;
                            tw_last  <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_twiddle_seq_rom.sv
// Bench for twiddle_seq_rom: a table of stage runs, hand-written corner sequences, random runs
// with random backpressure, and a small second instance that exercises im saturation.
module tb_twiddle_seq_rom;
    localparam int LOG2N = 4;
    localparam int TW_W  = 28;
    localparam int SW    = 3;
    localparam int HALF  = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start, conj, tw_ready;
    logic [SW-1:0]    stage_sel;
    logic             busy, done, err, tw_valid, tw_last;
    logic [TW_W-1:0]  tw_data;
    logic [LOG2N-2:0] tw_idx;

    logic             start2, conj2, ready2;
    logic [1:0]       stage2;
    logic             busy2, done2, err2, valid2, last2;
    logic [TW_W-1:0]  data2;
    logic [0:0]       idx2;

    always #5 clk = ~clk;

    twiddle_seq_rom #(.LOG2N(LOG2N), .TW_W(TW_W)) dut (
        .clk(clk), .rst(rst), .start(start), .stage_sel(stage_sel), .conj(conj),
        .busy(busy), .done(done), .err(err), .tw_valid(tw_valid), .tw_ready(tw_ready),
        .tw_data(tw_data), .tw_idx(tw_idx), .tw_last(tw_last));

    // N=4 image: k=0 -> {0x1000, 0x0000}, k=1 -> {0x0000, 0x2000 (most negative im)}
    twiddle_seq_rom #(.LOG2N(2), .TW_W(TW_W), .USE_IMG(1'b1),
                      .ROM_IMG({14'h0000, 14'h2000, 14'h1000, 14'h0000})) dut_sat (
        .clk(clk), .rst(rst), .start(start2), .stage_sel(stage2), .conj(conj2),
        .busy(busy2), .done(done2), .err(err2), .tw_valid(valid2), .tw_ready(ready2),
        .tw_data(data2), .tw_idx(idx2), .tw_last(last2));

    int total = 0;
    int bad   = 0;

    // W_16^k scaled by 4096, rounded: re = cos(2*pi*k/16), im = -sin(2*pi*k/16)
    int RE[8] = '{4096, 3784, 2896, 1567, 0, -1567, -2896, -3784};
    int IM[8] = '{0, -1567, -2896, -3784, -4096, -3784, -2896, -1567};

    typedef struct {
        int stage;
        bit cj;
        bit rnd;
        int poke;
        int poke_stage;
        bit legal;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_k(input int s, input int jj);
        return (jj % (1 << (s - 1))) * (1 << (LOG2N - s));
    endfunction

    function automatic logic [27:0] make_word(input int re, input int im, input bit cj);
        int         imv;
        logic [13:0] rb, ib;
        imv = im;
        if (cj) imv = (im == -8192) ? 8191 : -im;
        rb = re[13:0];
        ib = imv[13:0];
        return {rb, ib};
    endfunction

    task automatic run_seq(input int s, input bit cj, input bit rnd, input int poke, input int poke_s);
        int  got, kk, cyc;
        bit  pend, fin, poked, r;
        got = 0; pend = 0; fin = 0; poked = 0; cyc = 0;
        @(negedge clk);
        start = 1'b1; stage_sel = SW'(s); conj = cj; tw_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; conj = ~cj;
        chk("busy_after_start", busy, 1);
        chk("valid_latency", tw_valid, 0);
        for (int c = 0; c < 200 && !fin; c++) begin
            @(negedge clk);
            start = 1'b0;
            chk("err_quiet", err, 0);
            if (pend) begin
                chk("done_pulse", done, 1);
                chk("valid_drop", tw_valid, 0);
                chk("busy_drop", busy, 0);
                fin = 1;
                cyc = c;
            end else begin
                chk("busy_run", busy, 1);
                chk("done_low", done, 0);
                if (tw_valid) begin
                    kk = exp_k(s, got);
                    chk("tw_idx", tw_idx, kk);
                    chk("tw_data", tw_data, make_word(RE[kk], IM[kk], cj));
                    chk("tw_last", tw_last, got == HALF - 1);
                end
                r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (poke >= 0 && !poked && tw_valid && got == poke) begin
                    start = 1'b1; stage_sel = SW'(poke_s); poked = 1; r = 1'b1;
                end
                tw_ready = r;
                if (tw_valid && r) begin
                    if (got == HALF - 1) pend = 1;
                    got++;
                end
            end
        end
        if (!fin) chk("seq_timeout", 1, 0);
        chk("beat_count", got, HALF);
        if (!rnd) chk("cycle_count", cyc, HALF);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("no_restart", busy, 0);
        chk("idle_valid", tw_valid, 0);
        chk("idle_err", err, 0);
    endtask

    task automatic run_bad(input int s);
        @(negedge clk);
        start = 1'b1; stage_sel = SW'(s); tw_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", err, 1);
        chk("bad_busy", busy, 0);
        chk("bad_valid", tw_valid, 0);
        repeat (2) begin
            @(negedge clk);
            chk("err_cleared", err, 0);
            chk("bad_valid_later", tw_valid, 0);
            chk("bad_busy_later", busy, 0);
        end
    endtask

    initial begin
        vecs[0] = '{2, 1'b0, 1'b0, -1, 0, 1'b1};
        vecs[1] = '{4, 1'b1, 1'b0, -1, 0, 1'b1};
        vecs[2] = '{3, 1'b0, 1'b1, -1, 0, 1'b1};
        vecs[3] = '{1, 1'b1, 1'b0, -1, 0, 1'b1};
        vecs[4] = '{0, 1'b0, 1'b0, -1, 0, 1'b0};
        vecs[5] = '{5, 1'b0, 1'b0, -1, 0, 1'b0};
        vecs[6] = '{7, 1'b1, 1'b0, -1, 0, 1'b0};
        vecs[7] = '{4, 1'b0, 1'b0, 3, 0, 1'b1};
        vecs[8] = '{3, 1'b1, 1'b0, 7, 2, 1'b1};
        vecs[9] = '{4, 1'b0, 1'b0, -1, 0, 1'b1};

        rst = 1'b1; start = 1'b0; stage_sel = '0; conj = 1'b0; tw_ready = 1'b0;
        start2 = 1'b0; stage2 = '0; conj2 = 1'b0; ready2 = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", tw_valid, 0);
        chk("rst_data", tw_data, 0);
        chk("rst_idx", tw_idx, 0);
        chk("rst_flags", {done, err, tw_last}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", tw_valid, 0);
        chk("post_rst_busy", busy, 0);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].legal) run_seq(vecs[i].stage, vecs[i].cj, vecs[i].rnd, vecs[i].poke, vecs[i].poke_stage);
            else run_bad(vecs[i].stage);
        end

        // asynchronous reset while beat j=3 of stage 4 is on the output
        @(negedge clk);
        start = 1'b1; stage_sel = 3'd4; conj = 1'b0; tw_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 20 && !(tw_valid && tw_idx == 3'd3); c++) @(negedge clk);
        chk("pre_rst_idx", tw_idx, 3);
        rst = 1'b1;
        #1;
        chk("midrun_rst_valid", tw_valid, 0);
        chk("midrun_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("after_rst_quiet", {busy, tw_valid}, 0);
        end

        for (int i = 0; i < 12; i++) begin
            int s;
            s = $urandom_range(0, 7);
            if (s >= 1 && s <= LOG2N) run_seq(s, 1'($urandom_range(0, 1)), 1'b1, -1, 0);
            else run_bad(s);
        end

        // im = most negative value saturates under conjugation
        for (int c2 = 0; c2 < 2; c2++) begin
            @(negedge clk);
            start2 = 1'b1; stage2 = 2'd2; conj2 = c2[0]; ready2 = 1'b1;
            @(negedge clk);
            start2 = 1'b0;
            @(negedge clk);
            chk("sat_b0_valid", valid2, 1);
            chk("sat_b0_data", data2, {14'h1000, 14'h0000});
            @(negedge clk);
            chk("sat_b1_idx", idx2, 1);
            chk("sat_b1_last", last2, 1);
            chk("sat_b1_data", data2, c2 ? {14'h0000, 14'h1FFF} : {14'h0000, 14'h2000});
            @(negedge clk);
            chk("sat_done", {done2, valid2, err2}, 3'b100);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
